// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory port between fetch and data
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_req/i_addr          fetch read request (held until i_gnt)
//   i_gnt                 fetch request issued this cycle (combinational)
//   i_rvalid/i_rdata      fetch response
//   d_req/d_we/d_addr/d_wdata  data-stage request (held until d_gnt)
//   d_gnt                 data request issued this cycle (combinational)
//   d_rvalid/d_rdata      data response / write completion
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, one mem_en pulse per transaction
//   mem_rdata             memory read data, valid MEM_LATENCY cycles after mem_en
//   busy                  a transaction is outstanding
module mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    src_t            owner_q;
    src_t            last_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic resp_cycle;
    logic can_issue;
    logic gnt_i;
    logic gnt_d;

    // The response cycle doubles as an issue slot so sustained traffic
    // runs back-to-back with no idle bubble.
    assign resp_cycle = (state_q == S_WAIT) && (cnt_q == CW'(1));
    assign can_issue  = (state_q == S_IDLE) || resp_cycle;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (can_issue) begin
            if (i_req && d_req) begin
                // Tie: favour whichever side did not win last.
                if (last_q == SRC_FETCH) gnt_d = 1'b1;
                else                     gnt_i = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end else if (i_req) begin
                gnt_i = 1'b1;
            end
        end
    end

    assign i_gnt     = gnt_i;
    assign d_gnt     = gnt_d;
    assign mem_en    = gnt_i | gnt_d;
    assign mem_we    = gnt_d & d_we;
    // Address/wdata hold their last driven value between transactions.
    assign mem_addr  = gnt_d ? d_addr : (gnt_i ? i_addr : addr_q);
    assign mem_wdata = mem_en ? d_wdata : wdata_q;

    // Response steering uses the owner of the transaction now completing;
    // a grant in the same cycle only updates owner at the edge.
    assign i_rvalid = resp_cycle && (owner_q == SRC_FETCH);
    assign d_rvalid = resp_cycle && (owner_q == SRC_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign busy     = (state_q == S_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= SRC_FETCH;
            last_q  <= SRC_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_i || gnt_d) begin
            state_q <= S_WAIT;
            cnt_q   <= CW'(MEM_LATENCY);
            owner_q <= gnt_d ? SRC_DATA : SRC_FETCH;
            last_q  <= gnt_d ? SRC_DATA : SRC_FETCH;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_IDLE;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one fixed-latency memory port between the pipeline's instruction-fetch stage and its memory-access stage. It sits between the core datapath and a unified instruction/data memory. At most one transaction is outstanding at a time. Fetch and data requests are arbitrated round-robin, and each response is steered back to the requester that owns it.

## Interface
Parameters:
- XLEN, 32, data and address width.
- MEM_LATENCY, 2, cycles from the issue cycle to read data valid on `mem_rdata`. Must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch requests a read; held until `i_gnt`.
- i_addr  in  XLEN  fetch address; stable while `i_req` is high.
- i_gnt  out  1  fetch request issued this cycle.
- i_rvalid  out  1  fetch response valid this cycle.
- i_rdata  out  XLEN  fetch read data, valid with `i_rvalid`.
- d_req  in  1  data-stage access request; held until `d_gnt`.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  write data.
- d_gnt  out  1  data request issued this cycle.
- d_rvalid  out  1  data response (read data or write completion) this cycle.
- d_rdata  out  XLEN  data read data, valid with `d_rvalid` when the access was a read.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by `mem_en`.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, valid exactly MEM_LATENCY cycles after `mem_en`.
- busy  out  1  a transaction is outstanding (state WAIT).

## Operation
State:
- `state` is IDLE or WAIT.
- `cnt` is a down-counter of width $clog2(MEM_LATENCY+1).
- `owner` is FETCH or DATA.
- `last` is FETCH or DATA.

The issue condition `can_issue` is true when `state == IDLE`, or when `state == WAIT && cnt == 1`. The second case is the response cycle, which allows back-to-back issue.

Grant selection is combinational and applies only while `can_issue`:
- Only `d_req` high → grant DATA.
- Only `i_req` high → grant FETCH.
- Both high → grant whichever of FETCH/DATA is not `last`.
- Neither high → no grant.

On a grant:
- Assert exactly one of `i_gnt`/`d_gnt`, and assert `mem_en=1`.
- `mem_addr` = winner's address.
- `mem_we` = `d_we` if DATA wins, else 0.
- `mem_wdata` = `d_wdata`.
- Next edge: `state`←WAIT, `cnt`←MEM_LATENCY, `owner`←winner, `last`←winner.

In WAIT:
- `cnt` decrements every cycle.
- When `cnt == 1`, assert `owner`'s rvalid (`i_rvalid` or `d_rvalid`).
- In that cycle, `i_rdata`/`d_rdata` = `mem_rdata`.
- If no new grant occurs in that cycle, the next state is IDLE.

Writes also complete after MEM_LATENCY cycles, with `d_rvalid` as the completion pulse. `d_rdata` is don't-care for writes.

Idle outputs: when there is no grant, `mem_en`=0, `mem_we`=0, and `mem_addr`/`mem_wdata` hold the last driven value. The bench does not check `mem_addr`/`mem_wdata` while `mem_en`=0.

A requester may drop `req` before being granted; this has no side effect. `req` is never dropped between grant and response, because the grant cycle is the handoff point.

## Timing
- Reset values (asynchronous):
  - `state`=IDLE, `cnt`=0, `owner`=FETCH, `last`=FETCH.
  - `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `mem_en`, `mem_we`, `busy` all 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0.
- Because `last` resets to FETCH, the first tie after reset goes to DATA.
- Latency: grant in cycle T → rvalid in cycle T+MEM_LATENCY. Grants are combinational in the same cycle as `req`; there is no request-to-grant bubble in IDLE.
- Throughput: one transaction per MEM_LATENCY cycles when requests are sustained.
- With MEM_LATENCY=1: every cycle is a response cycle. A grant may occur every cycle, and the rvalid for grant T is in T+1.
- Simultaneous response and new grant: both are allowed in the same cycle. The new grant reloads `cnt`; `owner` updates at the edge, after the current response has been steered.
- Reset mid-WAIT: the outstanding transaction is discarded. No rvalid is emitted for it, and any late `mem_rdata` is ignored.
- There are never two rvalids in one cycle, and never two grants in one cycle.

## Test plan
1. Reset with MEM_LATENCY=2 → all outputs 0 and `busy`=0. Hold `i_req`=`d_req`=0 for 5 cycles → `mem_en` never asserts.
2. Single fetch: `i_req`=1, `i_addr`=0x10 in cycle 1 → `i_gnt`=1, `mem_en`=1, `mem_addr`=0x10, `mem_we`=0 in cycle 1. Then `busy`=1 in cycles 2–3. `mem_rdata`=0x00500093 in cycle 3 → `i_rvalid`=1 and `i_rdata`=0x00500093 in cycle 3, with `d_rvalid`=0.
3. Tie after reset: `i_req`=`d_req`=1 in cycle 1, `d_addr`=0x40 → `d_gnt` in cycle 1. Then `d_rvalid` and `i_gnt` in cycle 3, and `i_rvalid` in cycle 5.
4. Sustained tie for 8 grants → grant order D,I,D,I,D,I,D,I at cycles 1,3,5,…; each rvalid matches its owner.
5. Write: `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF → `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0xDEADBEEF in the grant cycle. `d_rvalid` follows 2 cycles later. An `i_req` raised in the cycle after the grant sees `i_gnt`=0 until the response cycle.
6. Assert `reset` in the cycle after a fetch grant → `busy`=0 immediately, no `i_rvalid` ever for that fetch, and a new `i_req` after reset release is granted in its first cycle.
